// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bundle carrying an opaque payload and a control word
// between two pipeline stages.
interface pipe_stage_buf_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 16
);
    logic              valid;
    logic              ready;
    logic [WIDTH-1:0]  data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input ready);
    modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// Generic pipeline-stage register with optional 2-entry skid buffer, flush
// (bubble insertion) and saturating stall/flush performance counters.
module pipe_stage_buf #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_stage_buf_if.slave  up,
    pipe_stage_buf_if.master dn,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state, state_nx;
    logic [WIDTH-1:0]  main_data, main_data_nx;
    logic [WIDTH-1:0]  skid_data, skid_data_nx;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_nx;
    logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_nx;
    logic              rdy_q, rdy_nx;
    logic              in_ready, in_xfer, out_xfer;
    logic              stall_hit, flush_hit;

    // Skid mode takes in_ready from a register; single-entry mode lets a
    // draining head make room in the same cycle.
    assign in_ready  = (SKID != 0) ? rdy_q : (state == EMPTY || dn.ready);
    assign up.ready  = in_ready;
    assign in_xfer   = up.valid & in_ready;
    assign out_xfer  = dn.valid & dn.ready;

    assign dn.valid  = (state != EMPTY);
    assign dn.data   = main_data;
    assign dn.ctrl   = dn.valid ? main_ctrl : '0;
    assign occupancy = state;

    assign stall_hit = dn.valid & ~dn.ready;
    assign flush_hit = flush & (state != EMPTY);

    always_comb begin
        state_nx     = state;
        main_data_nx = main_data;
        main_ctrl_nx = main_ctrl;
        skid_data_nx = skid_data;
        skid_ctrl_nx = skid_ctrl;
        if (flush) begin
            state_nx     = EMPTY;
            main_data_nx = '0;
            main_ctrl_nx = '0;
            skid_data_nx = '0;
            skid_ctrl_nx = '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state_nx     = ONE;
                        main_data_nx = up.data;
                        main_ctrl_nx = up.ctrl;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_data_nx = up.data;
                        main_ctrl_nx = up.ctrl;
                    end else if (in_xfer) begin
                        state_nx     = TWO;
                        skid_data_nx = up.data;
                        skid_ctrl_nx = up.ctrl;
                    end else if (out_xfer) begin
                        state_nx = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        state_nx     = ONE;
                        main_data_nx = skid_data;
                        main_ctrl_nx = skid_ctrl;
                        skid_data_nx = '0;
                        skid_ctrl_nx = '0;
                    end
                end
                default: state_nx = EMPTY;
            endcase
        end
        rdy_nx = (state_nx != TWO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
            rdy_q     <= 1'b1;
        end else begin
            state     <= state_nx;
            main_data <= main_data_nx;
            main_ctrl <= main_ctrl_nx;
            skid_data <= skid_data_nx;
            skid_ctrl <= skid_ctrl_nx;
            rdy_q     <= rdy_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_hit && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_ONE;
            if (flush_hit && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomised scoreboard bench: three configurations (skid, no-skid, 2-bit
// counters) share clock and reset and are checked against a queue model.
module tb_pipe_stage_buf;
    localparam int W = 32;
    localparam int C = 16;

    logic clk = 1'b0;
    logic rst_n;
    bit   run;
    int   checks;
    int   failures;

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int SK = (g == 1) ? 0 : 1;
        localparam int CW = (g == 2) ? 2 : 16;
        localparam logic [CW-1:0] CMAX = '1;

        pipe_stage_buf_if #(.WIDTH(W), .CTRL_W(C)) up_i ();
        pipe_stage_buf_if #(.WIDTH(W), .CTRL_W(C)) dn_i ();

        logic          fl;
        logic [1:0]    occ;
        logic [CW-1:0] scnt;
        logic [CW-1:0] fcnt;

        pipe_stage_buf #(
            .WIDTH(W), .CTRL_W(C), .SKID(SK), .CNT_W(CW)
        ) dut (
            .clk(clk),
            .reset(rst_n),
            .flush(fl),
            .up(up_i.slave),
            .dn(dn_i.master),
            .occupancy(occ),
            .stall_cnt(scnt),
            .flush_cnt(fcnt)
        );

        logic [W+C-1:0] exp_q[$];
        int             c_occ;
        bit             c_flush, c_valid, c_oready, c_rdy, active;
        logic [W-1:0]   c_data;
        logic [C-1:0]   c_ctrl;
        logic [CW-1:0]  m_stall, m_flush;

        // Driver: updates the reference queue for the edge just passed,
        // then issues the next cycle's stimulus.
        initial begin
            c_occ = 0; c_flush = 0; c_valid = 0; c_oready = 0;
            c_rdy = 1; active = 0; c_data = '0; c_ctrl = '0;
            m_stall = '0; m_flush = '0;
            fl = 1'b0; up_i.valid = 1'b0; up_i.data = '0;
            up_i.ctrl = '0; dn_i.ready = 1'b0;
            forever begin
                @(posedge clk);
                if (rst_n !== 1'b1) begin
                    exp_q.delete();
                    m_stall = '0;
                    m_flush = '0;
                end else if (active) begin
                    if (c_occ != 0 && !c_oready && m_stall != CMAX)
                        m_stall = m_stall + 1'b1;
                    if (c_flush) begin
                        if (c_occ != 0 && m_flush != CMAX)
                            m_flush = m_flush + 1'b1;
                        exp_q.delete();
                    end else if (c_valid && c_rdy) begin
                        exp_q.push_back({c_data, c_ctrl});
                    end
                end
                #1;
                active   = (rst_n === 1'b1);
                c_occ    = exp_q.size();
                c_oready = ($urandom_range(0, 1) == 1);
                if (active && run) begin
                    c_valid = ($urandom_range(0, 3) != 0);
                    c_flush = ($urandom_range(0, 15) == 0);
                end else begin
                    c_valid = 1'b0;
                    c_flush = 1'b0;
                end
                c_data = $urandom;
                c_ctrl = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                c_rdy  = (SK != 0) ? (c_occ < 2) : (c_occ == 0 || c_oready);
                up_i.valid = c_valid;
                up_i.data  = c_data;
                up_i.ctrl  = c_ctrl;
                dn_i.ready = c_oready;
                fl         = c_flush;
            end
        end

        // Monitor: pops the expected head on each output transfer.
        initial begin
            logic [W+C-1:0] e;
            bit             p_stall;
            logic [W-1:0]   p_data;
            logic [C-1:0]   p_ctrl;
            p_stall = 0; p_data = '0; p_ctrl = '0;
            forever begin
                @(negedge clk);
                if (rst_n === 1'b1) begin
                    check($sformatf("cfg%0d occupancy", g), occ, exp_q.size());
                    check($sformatf("cfg%0d out_valid", g), dn_i.valid, exp_q.size() != 0);
                    check($sformatf("cfg%0d in_ready", g), up_i.ready, c_rdy);
                    check($sformatf("cfg%0d stall_cnt", g), scnt, m_stall);
                    check($sformatf("cfg%0d flush_cnt", g), fcnt, m_flush);
                    if (!dn_i.valid)
                        check($sformatf("cfg%0d bubble_ctrl", g), dn_i.ctrl, 0);
                    if (p_stall) begin
                        check($sformatf("cfg%0d hold_data", g), dn_i.data, p_data);
                        check($sformatf("cfg%0d hold_ctrl", g), dn_i.ctrl, p_ctrl);
                    end
                    if (dn_i.valid && dn_i.ready && exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check($sformatf("cfg%0d out_data", g), dn_i.data, e[W+C-1:C]);
                        check($sformatf("cfg%0d out_ctrl", g), dn_i.ctrl, e[C-1:0]);
                    end
                    p_stall = dn_i.valid && !dn_i.ready && !fl;
                    p_data  = dn_i.data;
                    p_ctrl  = dn_i.ctrl;
                end else begin
                    p_stall = 0;
                end
            end
        end

        // Reset must clear the visible state without waiting for a clock.
        initial begin
            forever begin
                @(negedge rst_n);
                #1;
                check($sformatf("cfg%0d rst_valid", g), dn_i.valid, 0);
                check($sformatf("cfg%0d rst_data", g), dn_i.data, 0);
                check($sformatf("cfg%0d rst_ctrl", g), dn_i.ctrl, 0);
                check($sformatf("cfg%0d rst_occ", g), occ, 0);
                check($sformatf("cfg%0d rst_stall", g), scnt, 0);
                check($sformatf("cfg%0d rst_flush", g), fcnt, 0);
                check($sformatf("cfg%0d rst_in_ready", g), up_i.ready, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        run      = 0;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #7 rst_n = 1'b1;
        run = 1;
        repeat (400) @(posedge clk);
        #7 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #7 rst_n = 1'b1;
        repeat (400) @(posedge clk);
        run = 0;
        repeat (6) @(posedge clk);
        #7;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Generic parametrised pipeline-stage register; successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque data payload plus a control bundle between two pipeline stages using a valid/ready handshake.
- Adds stall back-pressure, flush (bubble insertion with control zeroing), an optional 2-entry skid buffer, and saturating stall/flush performance counters.

Parameters:
- WIDTH, 32, payload (datapath) width in bits.
- CTRL_W, 16, control-bundle width in bits; forced to zero whenever the stage holds a bubble.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous kill of all held entries and of this cycle's input.
- in_valid  input  1  upstream offers in_data/in_ctrl.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  WIDTH  upstream payload.
- in_ctrl  input  CTRL_W  upstream control bundle.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts the head entry.
- out_data  output  WIDTH  head payload.
- out_ctrl  output  CTRL_W  head control bundle; all zeros when out_valid=0.
- occupancy  output  2  number of valid entries (0..2).
- stall_cnt  output  CNT_W  saturating count of stall cycles.
- flush_cnt  output  CNT_W  saturating count of effective flushes.

Behaviour:
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Latency: 1 cycle from accepted input to out_valid. Throughput: 1 per cycle. Strict FIFO order.
- Reset (reset=0, asynchronous):
  - All entries invalid; main and skid data/ctrl = 0.
  - out_valid=0, out_data=0, out_ctrl=0, occupancy=0, stall_cnt=0, flush_cnt=0.
  - in_ready=1 (SKID=1); in_ready=1 (SKID=0, since out_valid=0).
  - Reset asserted mid-transfer discards everything immediately; no partial update on deassertion.
- SKID=1 states: EMPTY, ONE, TWO (main register plus skid register). in_ready = (state != TWO), driven from a register.
  - EMPTY: input transfer -> ONE (main loaded).
  - ONE:
    - input and output transfer -> ONE (main replaced).
    - input transfer only -> TWO (skid loaded).
    - output transfer only -> EMPTY.
    - neither -> hold.
  - TWO: output transfer -> ONE (skid moves to main, skid cleared); otherwise hold. No input is possible because in_ready=0.
- SKID=0: single main entry, in_ready = ~out_valid | out_ready (combinational).
  - Input transfer loads main.
  - Output transfer with no input transfer -> empty.
- Flush (synchronous, priority over all handshake activity):
  - At the edge where flush=1, all entries are invalidated and main/skid data and ctrl are zeroed.
  - Any input transfer in the same cycle is dropped. The output transfer in that cycle still counts as completed downstream.
  - Next cycle: occupancy=0, in_ready=1.
- Bubble rule: out_ctrl = 0 whenever out_valid = 0, so no RegWrite/MemWrite-type control leaks from a bubble.
- Stall hold: while out_valid & ~out_ready, out_data and out_ctrl hold stable.
- stall_cnt: +1 each cycle with out_valid & ~out_ready; saturates at all-ones.
- flush_cnt: +1 each cycle with flush=1 and occupancy != 0; saturates at all-ones. A flush of an empty stage does not count.
- Both counters are cleared only by reset.

Test Plan:
- Reset, then SKID=1; stream in_data 1,2,3 back-to-back with out_ready=1 -> out_data 1,2,3 on cycles 1,2,3 after acceptance; occupancy stays 1; stall_cnt=0.
- SKID=1; push A=0x11 then B=0x22 with out_ready=0 -> occupancy=2, in_ready=0, out_data holds 0x11; raise out_ready -> 0x11 then 0x22 emerge in order; stall_cnt=2 or more.
- SKID=1, occupancy=2 with ctrl=0xFFFF; assert flush together with in_valid (data 0x33) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, 0x33 never appears, flush_cnt=1; flush again while empty -> flush_cnt stays 1.
- SKID=0; out_ready=0 with one entry held -> in_ready=0; set out_ready=1 and in_valid=1 in the same cycle -> in_ready=1 combinationally, new entry replaces old with no bubble.
- CNT_W=2; hold a stall for 6 cycles -> stall_cnt = 3 (saturated, no wrap).
- Assert reset asynchronously mid-stream with occupancy=2 -> outputs zero immediately without a clock edge; after deassertion the first accepted item appears after 1 cycle.
